// File: rtl/dpram_clr_if.sv
// ============================================================================
// dpram_clr_if : CPU and video port bundle for the clearable dual-port RAM
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface dpram_clr_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] q;
    logic                  rw;
    logic                  ce;
    logic                  clr;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] vaddr;
    logic [DATA_WIDTH-1:0] vdata;

    modport master (
        output addr, din, rw, ce, clr, vaddr,
        input  q, busy, vdata
    );

    modport slave (
        input  addr, din, rw, ce, clr, vaddr,
        output q, busy, vdata
    );
endinterface

`default_nettype wire

// File: rtl/dpram_clr.sv
// ============================================================================
// dpram_clr : dual-port video RAM with CPU port, registered video read port,
//             sequential clear engine and optional video write-forwarding
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_clr #(
    parameter int                    ADDR_WIDTH     = 12,
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] CLR_VAL        = '0,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter bit                    V_FWD          = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    dpram_clr_if.slave    bus
);
    localparam int                    C_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_LAST  = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem [C_DEPTH];

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_busy;
    logic                  r_start;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_vdata;

    logic                  w_clear;
    logic                  w_cpu_we;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_fwd;

    // Single write port shared by the CPU and the clear engine; the engine wins
    always_comb begin
        w_clear  = (r_state == ST_CLEAR);
        w_cpu_we = rst_n & ~bus.ce & bus.rw & ~w_clear;
        w_we     = w_cpu_we | (rst_n & w_clear);
        w_waddr  = w_clear ? r_cnt   : bus.addr;
        w_wdata  = w_clear ? CLR_VAL : bus.din;
        w_fwd    = V_FWD && w_we && (w_waddr == bus.vaddr);
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_vdata <= '0;
        end else begin
            r_data  <= mem[bus.addr];
            r_vdata <= w_fwd ? w_wdata : mem[bus.vaddr];
        end
    end

    // r_start remembers a pending power-on sweep until the first active edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_start <= CLEAR_ON_RESET;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.clr || r_start) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q     = (~bus.ce & ~r_busy) ? r_data : '0;
    assign bus.busy  = r_busy;
    assign bus.vdata = r_vdata;

endmodule

`default_nettype wire

// File: tb/tb_dpram_clr.sv
// ============================================================================
// tb_dpram_clr : directed self-checking bench for dpram_clr (16x8, fill A5)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dpram_clr;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] addr, vaddr;
    logic [7:0] din;
    logic       rw, ce, clr;

    int n_pass  = 0;
    int n_total = 0;

    dpram_clr_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) b1 ();
    dpram_clr_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) b0 ();

    assign b1.addr = addr;  assign b0.addr = addr;
    assign b1.din  = din;   assign b0.din  = din;
    assign b1.rw   = rw;    assign b0.rw   = rw;
    assign b1.ce   = ce;    assign b0.ce   = ce;
    assign b1.clr  = clr;   assign b0.clr  = clr;
    assign b1.vaddr = vaddr; assign b0.vaddr = vaddr;

    dpram_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .CLR_VAL(8'hA5),
                .CLEAR_ON_RESET(1'b1), .V_FWD(1'b1))
        u_fwd (.clk(clk), .rst_n(rst_n), .bus(b1));

    dpram_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .CLR_VAL(8'hA5),
                .CLEAR_ON_RESET(1'b1), .V_FWD(1'b0))
        u_nofwd (.clk(clk), .rst_n(rst_n), .bus(b0));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %b, expected %b", name, act, exp);
        else n_pass++;
    endtask

    // Counts busy-high cycles over a fixed window, checking q stays 0 meanwhile
    task automatic count_sweep(input string name);
        int nb = 0;
        int qbad = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (b1.busy === 1'b1) begin
                nb++;
                if (b1.q !== 8'h00) qbad++;
            end
        end
        n_total++;
        if (nb != 16) $display("FAIL %s_len: got %0d busy cycles, expected 16", name, nb);
        else n_pass++;
        n_total++;
        if (qbad != 0) $display("FAIL %s_q: got %0d nonzero q while busy, expected 0", name, qbad);
        else n_pass++;
    endtask

    task automatic check_all_a5(input string name);
        for (int a = 0; a < 16; a++) begin
            vaddr = 4'(a);
            tick();
            chk8($sformatf("%s_v%0d", name, a), b1.vdata, 8'hA5);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (b1.busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk1({name, "_idle"}, b1.busy, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b0; rw = 1'b0; clr = 1'b0;
        addr = '0; din = '0; vaddr = '0;
        repeat (3) tick();
        chk1("rst_busy", b1.busy, 1'b0);
        chk8("rst_vdata", b1.vdata, 8'h00);
        chk8("rst_q", b1.q, 8'h00);
        rst_n = 1'b1;
        count_sweep("auto_clr");
        check_all_a5("auto_clr");
    endtask

    task automatic test_basic_rw();
        addr = 4'd7; din = 8'h3C; rw = 1'b1; ce = 1'b0;
        tick();
        chk8("rbw_old", b1.q, 8'hA5);
        rw = 1'b0;
        tick();
        chk8("rd_q", b1.q, 8'h3C);
        ce = 1'b1;
        #1;
        chk8("ce_gate", b1.q, 8'h00);
        vaddr = 4'd7;
        tick();
        chk8("rd_vdata", b1.vdata, 8'h3C);
    endtask

    task automatic test_forward();
        addr = 4'd2; vaddr = 4'd2; din = 8'h5A; rw = 1'b1; ce = 1'b0;
        tick();
        rw = 1'b0;
        chk8("fwd_on", b1.vdata, 8'h5A);
        chk8("fwd_off_old", b0.vdata, 8'hA5);
        tick();
        chk8("fwd_off_new", b0.vdata, 8'h5A);
    endtask

    task automatic test_clr_block();
        ce = 1'b1; rw = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk1("clr_busy", b1.busy, 1'b1);
        addr = 4'd3; din = 8'hFF; rw = 1'b1; ce = 1'b0;
        tick();
        chk8("clr_q0", b1.q, 8'h00);
        rw = 1'b0;
        wait_idle("clr");
        chk8("clr_drop", b1.q, 8'hA5);
        vaddr = 4'd7;
        tick();
        chk8("clr_a7", b1.vdata, 8'hA5);
    endtask

    task automatic test_reset_mid();
        addr = 4'd12; din = 8'h77; rw = 1'b1; ce = 1'b0; vaddr = 4'd0;
        tick();
        rw = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (8) tick();
        chk1("mid_busy_pre", b1.busy, 1'b1);
        chk8("mid_vdata_pre", b1.vdata, 8'hA5);
        rst_n = 1'b0;
        #1;
        chk1("mid_busy", b1.busy, 1'b0);
        chk8("mid_vdata", b1.vdata, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        count_sweep("mid_restart");
        check_all_a5("mid_restart");
    endtask

    task automatic test_collision();
        addr = 4'd15; din = 8'h11; rw = 1'b1; ce = 1'b0; clr = 1'b1;
        tick();
        rw = 1'b0; clr = 1'b0; vaddr = 4'd15;
        chk1("col_busy", b1.busy, 1'b1);
        tick();
        chk8("col_written", b1.vdata, 8'h11);
        wait_idle("col");
        tick();
        chk8("col_overwritten", b1.vdata, 8'hA5);
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_forward();
        test_clr_block();
        test_reset_mid();
        test_collision();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
